// File: rtl/branch_ctrl_pkg.sv
// Shared types and helpers for the branch redirect controller.
//   state_t  : controller FSM states (IDLE, RESOLVE, FLUSH)
//   kind_t   : latched control-flow op kind (BR, JAL, JALR)
//   FLUSH_CNT_W / flush_cnt_width() : width of the squash-window counter
//   decode_kind() : op-flag priority encoder (JAL > JALR > conditional branch)
package branch_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RESOLVE = 2'd1,
        FLUSH   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        BR   = 2'd0,
        JAL  = 2'd1,
        JALR = 2'd2
    } kind_t;

    localparam int DEFAULT_FLUSH_DEPTH = 2;
    localparam int FLUSH_CNT_W         = $clog2(DEFAULT_FLUSH_DEPTH + 1);

    // Counter width for an arbitrary flush depth; the controller calls this
    // with its own FLUSH_DEPTH parameter.
    function automatic int flush_cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Several op flags may be high on a malformed decode; jumps win.
    function automatic kind_t decode_kind(input logic jal, input logic jalr);
        if (jal)
            return JAL;
        else if (jalr)
            return JALR;
        else
            return BR;
    endfunction

endpackage

// File: rtl/branch_redirect_ctrl_sat_counter.sv
// sat_counter: saturating up-counter used for redirect statistics.
//   clk  : core clock
//   rstB : synchronous active-low reset, clears the count
//   inc  : add one this cycle (ignored once the count is all-ones)
//   cnt  : current count
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rstB,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (!rstB)
            cnt_reg <= '0;
        else if (inc && (cnt_reg != {CNT_W{1'b1}}))
            cnt_reg <= cnt_reg + 1'b1;
    end

    assign cnt = cnt_reg;

endmodule

// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl: sequences fetch redirects for resolved control-flow ops.
//   clk, rstB        : clock, synchronous active-low reset
//   stall            : freezes the FSM and the flush counter
//   exe_valid, b_type, op_jal, op_jalr : op entering execute
//   Cond, pc_jmpto   : branch unit result, valid one cycle after acceptance
//   pc_load, pc_next : fetch PC redirect strobe and target
//   flush_if/_id     : squash younger instructions
//   ctrl_busy        : FSM outside IDLE
//   misaligned_err   : taken target with nonzero [1:0]
//   taken_cnt, jump_cnt : saturating statistics
module branch_redirect_ctrl
    import branch_ctrl_pkg::*;
#(
    parameter int FLUSH_DEPTH = 2,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rstB,
    input  logic             stall,
    input  logic             exe_valid,
    input  logic             b_type,
    input  logic             op_jal,
    input  logic             op_jalr,
    input  logic             Cond,
    input  logic [31:0]      pc_jmpto,
    output logic             pc_load,
    output logic [31:0]      pc_next,
    output logic             flush_if,
    output logic             flush_id,
    output logic             ctrl_busy,
    output logic             misaligned_err,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] jump_cnt
);

    localparam int              FC_W         = flush_cnt_width(FLUSH_DEPTH);
    // The RESOLVE cycle is the first flush cycle, so FLUSH covers the rest.
    localparam logic [FC_W-1:0] FLUSH_RELOAD = FC_W'(FLUSH_DEPTH - 1);

    state_t          state_reg, state_next;
    kind_t           kind_reg, kind_next;
    logic [FC_W-1:0] flush_cnt_reg, flush_cnt_next;
    logic [31:0]     pc_next_reg;

    logic accept, decide, taken, aligned, redirect;
    logic [1:0]       inc_vec;
    logic [CNT_W-1:0] cnt_arr [2];

    always_comb begin
        accept   = (state_reg == IDLE) && exe_valid && !stall
                   && (b_type || op_jal || op_jalr);
        decide   = (state_reg == RESOLVE) && !stall;
        taken    = (kind_reg != BR) || Cond;
        aligned  = (pc_jmpto[1:0] == 2'b00);
        redirect = decide && taken && aligned;

        state_next     = state_reg;
        kind_next      = kind_reg;
        flush_cnt_next = flush_cnt_reg;

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    kind_next  = decode_kind(op_jal, op_jalr);
                    state_next = RESOLVE;
                end
            end
            RESOLVE: begin
                if (!stall) begin
                    if (redirect) begin
                        flush_cnt_next = FLUSH_RELOAD;
                        state_next     = (FLUSH_RELOAD != '0) ? FLUSH : IDLE;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            FLUSH: begin
                if (!stall) begin
                    flush_cnt_next = flush_cnt_reg - 1'b1;
                    if (flush_cnt_reg == FC_W'(1))
                        state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstB) begin
            state_reg     <= IDLE;
            kind_reg      <= BR;
            flush_cnt_reg <= '0;
            pc_next_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            kind_reg      <= kind_next;
            flush_cnt_reg <= flush_cnt_next;
            if (redirect)
                pc_next_reg <= pc_jmpto;
        end
    end

    // Decision strobes are combinational; an asserted reset masks them so an
    // aborted RESOLVE never leaks a redirect into fetch.
    assign pc_load        = rstB && redirect;
    assign flush_if       = rstB && (redirect || (state_reg == FLUSH));
    assign flush_id       = flush_if;
    assign misaligned_err = rstB && decide && taken && !aligned;
    assign ctrl_busy      = (state_reg != IDLE);
    assign pc_next        = pc_next_reg;

    // Index 0: taken conditional branches, index 1: JAL/JALR redirects.
    assign inc_vec[0] = redirect && (kind_reg == BR);
    assign inc_vec[1] = redirect && (kind_reg != BR);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_stat
            sat_counter #(
                .CNT_W (CNT_W)
            ) u_cnt (
                .clk  (clk),
                .rstB (rstB),
                .inc  (inc_vec[gi]),
                .cnt  (cnt_arr[gi])
            );
        end
    endgenerate

    assign taken_cnt = cnt_arr[0];
    assign jump_cnt  = cnt_arr[1];

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Self-checking bench for branch_redirect_ctrl. Each transaction is described
// by its op kind, condition, target and stall pattern; the expected per-cycle
// outputs are derived from those rules, not from the controller's internals.
module tb_branch_redirect_ctrl;

    localparam int FD   = 2;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rstB, stall, exe_valid, b_type, op_jal, op_jalr, Cond;
    logic [31:0]   pc_jmpto;
    logic          pc_load, flush_if, flush_id, ctrl_busy, misaligned_err;
    logic [31:0]   pc_next;
    logic [CW-1:0] taken_cnt, jump_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    int txn_id   = 0;

    // Reference model state
    logic [31:0] exp_pc;
    int          exp_taken, exp_jump;

    branch_redirect_ctrl #(
        .FLUSH_DEPTH (FD),
        .CNT_W       (CW)
    ) dut (
        .clk            (clk),
        .rstB           (rstB),
        .stall          (stall),
        .exe_valid      (exe_valid),
        .b_type         (b_type),
        .op_jal         (op_jal),
        .op_jalr        (op_jalr),
        .Cond           (Cond),
        .pc_jmpto       (pc_jmpto),
        .pc_load        (pc_load),
        .pc_next        (pc_next),
        .flush_if       (flush_if),
        .flush_id       (flush_id),
        .ctrl_busy      (ctrl_busy),
        .misaligned_err (misaligned_err),
        .taken_cnt      (taken_cnt),
        .jump_cnt       (jump_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s obs=0x%08h exp=0x%08h (txn %0d)", tag, obs, exp, txn_id);
        else
            n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        exp_pc    = '0;
        exp_taken = 0;
        exp_jump  = 0;
    endtask

    // Random op flags and branch-unit values that the controller must ignore.
    task automatic noise();
        exe_valid = 1'($urandom);
        b_type    = 1'($urandom);
        op_jal    = 1'($urandom);
        op_jalr   = 1'($urandom);
        Cond      = 1'($urandom);
        pc_jmpto  = $urandom;
    endtask

    task automatic check_strobes(input string tag, input bit busy, input bit load,
                                 input bit fl, input bit mis);
        chk({tag, "_busy"}, 32'(ctrl_busy), 32'(busy));
        chk({tag, "_pc_load"}, 32'(pc_load), 32'(load));
        chk({tag, "_flush_if"}, 32'(flush_if), 32'(fl));
        chk({tag, "_flush_id"}, 32'(flush_id), 32'(fl));
        chk({tag, "_mis"}, 32'(misaligned_err), 32'(mis));
    endtask

    task automatic check_idle(input string tag);
        exe_valid = 1'b0;
        stall     = 1'b0;
        #1;
        check_strobes(tag, 1'b0, 1'b0, 1'b0, 1'b0);
        chk({tag, "_pc_next"}, pc_next, exp_pc);
        chk({tag, "_taken_cnt"}, 32'(taken_cnt), 32'(exp_taken));
        chk({tag, "_jump_cnt"}, 32'(jump_cnt), 32'(exp_jump));
    endtask

    // kind: 0=BR 1=JAL 2=JALR. rst_at: 0 none, 1 reset in RESOLVE, 2 reset in
    // the first FLUSH cycle. Starts and ends with the DUT idle at posedge+1.
    task automatic txn(input int kind, input bit cond, input logic [31:0] tgt,
                       input int rs_stalls, input int fl_stalls, input int rst_at);
        bit taken, aligned, load;
        int rem, budget;
        txn_id++;
        rstB = 1'b1; stall = 1'b0; exe_valid = 1'b1;
        Cond = 1'($urandom); pc_jmpto = $urandom;
        case (kind)
            0:       begin b_type = 1'b1; op_jal = 1'b0; op_jalr = 1'b0; end
            1:       begin op_jal = 1'b1; op_jalr = 1'($urandom); b_type = 1'($urandom); end
            default: begin op_jal = 1'b0; op_jalr = 1'b1; b_type = 1'($urandom); end
        endcase
        #1;
        check_strobes("accept", 1'b0, 1'b0, 1'b0, 1'b0);
        step();

        for (int i = 0; i < rs_stalls; i++) begin
            noise();
            stall = 1'b1;
            #1;
            check_strobes("res_stall", 1'b1, 1'b0, 1'b0, 1'b0);
            step();
        end

        if (rst_at == 1) begin
            noise();
            stall = 1'b0;
            Cond = 1'b1; pc_jmpto = 32'h0000_0400;
            rstB = 1'b0;
            step();
            rstB = 1'b1;
            model_reset();
            check_idle("rst_res");
            $display("txn %0d kind=%0d reset during RESOLVE", txn_id, kind);
            return;
        end

        noise();
        stall    = 1'b0;
        Cond     = cond;
        pc_jmpto = tgt;
        taken    = (kind != 0) || cond;
        aligned  = (tgt[1:0] == 2'b00);
        load     = taken && aligned;
        #1;
        check_strobes("decide", 1'b1, load, load, taken && !aligned);
        if (load)
            chk("decide_pc_target", pc_next, exp_pc);   // old value until the edge
        step();
        if (load) begin
            exp_pc = tgt;
            if (kind == 0) begin
                if (exp_taken < CMAX) exp_taken++;
            end else begin
                if (exp_jump < CMAX) exp_jump++;
            end
        end

        if (load) begin
            rem    = FD - 1;
            budget = fl_stalls;
            while (rem > 0) begin
                noise();
                if (rst_at == 2) begin
                    stall = 1'b0;
                    rstB  = 1'b0;
                    step();
                    rstB = 1'b1;
                    model_reset();
                    check_idle("rst_flush");
                    $display("txn %0d kind=%0d reset during FLUSH", txn_id, kind);
                    return;
                end
                stall = (budget > 0);
                #1;
                check_strobes("flush", 1'b1, 1'b0, 1'b1, 1'b0);
                step();
                if (stall) budget--;
                else       rem--;
            end
        end

        check_idle("done");
        $display("txn %0d kind=%0d cond=%0d tgt=0x%08h rs_st=%0d fl_st=%0d load=%0d taken_cnt=%0d jump_cnt=%0d",
                 txn_id, kind, cond, tgt, rs_stalls, fl_stalls, load, taken_cnt, jump_cnt);
    endtask

    // One idle cycle whose op flags must not be accepted (invalid or stalled).
    task automatic idle_gap();
        noise();
        if ($urandom % 2) exe_valid = 1'b0;
        else              stall     = 1'b1;
        step();
        check_idle("gap");
    endtask

    initial begin
        logic [31:0] tgt;
        int          rsel;
        rstB = 1'b0; stall = 1'b0; exe_valid = 1'b0; b_type = 1'b0;
        op_jal = 1'b0; op_jalr = 1'b0; Cond = 1'b0; pc_jmpto = '0;
        model_reset();
        noise();
        step();
        step();
        rstB = 1'b1;
        check_idle("reset");

        // Directed cases
        txn(0, 1'b0, 32'h0000_0100, 0, 0, 0);          // not taken
        txn(0, 1'b1, 32'h0000_0100, 0, 0, 0);          // taken branch
        txn(1, 1'b0, 32'h0000_0200, 2, 1, 0);          // JAL with stalls
        txn(2, 1'b1, 32'h0000_0102, 0, 0, 0);          // misaligned JALR
        txn(1, 1'b1, 32'h0000_0300, 0, 0, 2);          // reset mid-FLUSH
        txn(2, 1'b1, 32'h0000_0500, 1, 0, 1);          // reset mid-RESOLVE
        for (int i = 0; i < 17; i++)                   // saturation
            txn(0, 1'b1, 32'h0000_1000 + 32'(i * 4), 0, 0, 0);
        chk("sat_taken_cnt", 32'(taken_cnt), 32'(CMAX));

        // Randomized traffic
        for (int t = 0; t < 120; t++) begin
            tgt = $urandom & 32'hFFFF_FFFC;
            if ($urandom % 5 == 0) tgt[1:0] = 2'($urandom_range(1, 3));
            rsel = ($urandom % 25 == 0) ? int'($urandom_range(1, 2)) : 0;
            txn(int'($urandom % 3), 1'($urandom), tgt,
                int'($urandom % 3), int'($urandom % 3), rsel);
            if ($urandom % 4 == 0) idle_gap();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
